// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the RV32I pipeline.
// Executes CSR read-modify-write, trap entry, mret and one-cycle fetch redirects.
module csr_unit #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_we,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wsrc,
   output logic [31:0] csr_dout,
   output logic        illegal_csr,
   input  logic        trap_valid,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_val,
   input  logic        mret,
   input  logic        ext_irq,
   output logic        irq_req,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam logic [11:0] A_MSTATUS  = 12'h300;
   localparam logic [11:0] A_MISA     = 12'h301;
   localparam logic [11:0] A_MIE      = 12'h304;
   localparam logic [11:0] A_MTVEC    = 12'h305;
   localparam logic [11:0] A_MSCRATCH = 12'h340;
   localparam logic [11:0] A_MEPC     = 12'h341;
   localparam logic [11:0] A_MCAUSE   = 12'h342;
   localparam logic [11:0] A_MTVAL    = 12'h343;
   localparam logic [11:0] A_MIP      = 12'h344;
   localparam logic [11:0] A_MCYCLE   = 12'hB00;
   localparam logic [11:0] A_MCYCLEH  = 12'hB80;
   localparam logic [11:0] A_CYCLE    = 12'hC00;
   localparam logic [11:0] A_CYCLEH   = 12'hC80;
   localparam logic [11:0] A_MHARTID  = 12'hF14;

   logic        mie_q, mpie_q, meie_q;
   logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0] mcycle_q;
   logic        sync1_q, meip_q;
   logic        redirect_q;
   logic [31:0] redirect_pc_q;

   logic [31:0] rdata_d, wval_d, mstatus_d;
   logic        mapped_d, ro_d, wr_req_d, illegal_d, do_wr_d;

   assign mstatus_d = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

   always_comb begin
      rdata_d  = 32'h0;
      mapped_d = 1'b1;
      unique case (csr_addr)
         A_MSTATUS:           rdata_d = mstatus_d;
         A_MISA:              rdata_d = 32'h4000_0100;
         A_MIE:               rdata_d = {20'b0, meie_q, 11'b0};
         A_MTVEC:             rdata_d = mtvec_q;
         A_MSCRATCH:          rdata_d = mscratch_q;
         A_MEPC:              rdata_d = mepc_q;
         A_MCAUSE:            rdata_d = mcause_q;
         A_MTVAL:             rdata_d = mtval_q;
         A_MIP:               rdata_d = {20'b0, meip_q, 11'b0};
         A_MCYCLE, A_CYCLE:   rdata_d = mcycle_q[31:0];
         A_MCYCLEH, A_CYCLEH: rdata_d = mcycle_q[63:32];
         A_MHARTID:           rdata_d = HART_ID;
         default:             mapped_d = 1'b0;
      endcase
   end

   // RS/RC with a zero source are pure reads and must not trip the read-only check.
   always_comb begin
      ro_d     = (csr_addr == A_CYCLE) || (csr_addr == A_CYCLEH) || (csr_addr == A_MHARTID);
      wr_req_d = csr_we && ((csr_op == OP_RW) || ((csr_op != OP_NONE) && (csr_wsrc != 32'h0)));
      unique case (csr_op)
         OP_RW:   wval_d = csr_wsrc;
         OP_RS:   wval_d = rdata_d | csr_wsrc;
         OP_RC:   wval_d = rdata_d & ~csr_wsrc;
         default: wval_d = rdata_d;
      endcase
      illegal_d = csr_we && (!mapped_d || (wr_req_d && ro_d));
      do_wr_d   = wr_req_d && !illegal_d && !trap_valid && !mret;
   end

   assign csr_dout    = illegal_d ? 32'h0 : rdata_d;
   assign illegal_csr = illegal_d;
   assign irq_req     = mie_q & meie_q & meip_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         meie_q        <= 1'b0;
         mtvec_q       <= MTVEC_RST & ~32'h3;
         mscratch_q    <= 32'h0;
         mepc_q        <= 32'h0;
         mcause_q      <= 32'h0;
         mtval_q       <= 32'h0;
         mcycle_q      <= 64'h0;
         sync1_q       <= 1'b0;
         meip_q        <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'h0;
      end else begin
         sync1_q    <= ext_irq;
         meip_q     <= sync1_q;
         redirect_q <= trap_valid || mret;
         mcycle_q   <= mcycle_q + 64'd1;
         if (trap_valid) begin
            mepc_q        <= trap_pc & ~32'h3;
            mcause_q      <= trap_cause;
            mtval_q       <= trap_val;
            mpie_q        <= mie_q;
            mie_q         <= 1'b0;
            redirect_pc_q <= mtvec_q;
         end else if (mret) begin
            mie_q         <= mpie_q;
            mpie_q        <= 1'b1;
            redirect_pc_q <= mepc_q;
         end else if (do_wr_d) begin
            unique case (csr_addr)
               A_MSTATUS: begin
                  mie_q  <= wval_d[3];
                  mpie_q <= wval_d[7];
               end
               A_MIE:      meie_q     <= wval_d[11];
               A_MTVEC:    mtvec_q    <= wval_d & ~32'h3;
               A_MSCRATCH: mscratch_q <= wval_d;
               A_MEPC:     mepc_q     <= wval_d & ~32'h3;
               A_MCAUSE:   mcause_q   <= wval_d;
               A_MTVAL:    mtval_q    <= wval_d;
               // A written half replaces the counter and skips this cycle's increment.
               A_MCYCLE:   mcycle_q   <= {mcycle_q[63:32], wval_d};
               A_MCYCLEH:  mcycle_q   <= {wval_d, mcycle_q[31:0]};
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit: table of CSR accesses plus hand-written
// trap, mret, interrupt, counter and reset sequences.
module tb_csr_unit;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0200;
   localparam logic [31:0] HART_ID   = 32'h0000_0007;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_we;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wsrc;
   logic [31:0] csr_dout;
   logic        illegal_csr;
   logic        trap_valid;
   logic [31:0] trap_cause, trap_pc, trap_val;
   logic        mret;
   logic        ext_irq;
   logic        irq_req;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;
   int unsigned ncyc;

   csr_unit #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
      .clk(clk), .rst(rst),
      .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wsrc(csr_wsrc),
      .csr_dout(csr_dout), .illegal_csr(illegal_csr),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
      .mret(mret), .ext_irq(ext_irq), .irq_req(irq_req),
      .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // Reference cycle count since the last reset edge.
   always @(posedge clk) begin
      if (rst) ncyc <= 0;
      else     ncyc <= ncyc + 1;
   end

   typedef struct {
      logic        we;
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic [31:0] dout;
      logic        ill;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic idle();
      csr_we = 0; csr_op = 2'b00; csr_addr = 12'h000; csr_wsrc = 0;
      trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_val = 0; mret = 0;
   endtask

   task automatic csr(input logic we, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] s);
      csr_we = we; csr_op = op; csr_addr = a; csr_wsrc = s;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
      csr(1'b0, 2'b00, a, 32'h0);
      #1;
      chk(nm, csr_dout, exp);
   endtask

   initial begin
      idle();
      ext_irq = 0;
      rst = 1;

      tv.push_back('{1'b0, 2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h305, 32'h0,         MTVEC_RST,     1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h301, 32'h0,         32'h4000_0100, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'hF14, 32'h0,         HART_ID,       1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h123, 32'h0,         32'h0,         1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h340, 32'hA5A5_0000, 32'h0,         1'b0});
      tv.push_back('{1'b1, 2'd2, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0});
      tv.push_back('{1'b1, 2'd3, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h340, 32'h0,         32'h00A5_00FF, 1'b0});
      tv.push_back('{1'b1, 2'd2, 12'h340, 32'h0,         32'h00A5_00FF, 1'b0});
      tv.push_back('{1'b1, 2'd3, 12'h340, 32'h0,         32'h00A5_00FF, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h123, 32'h5,         32'h0,         1'b1});
      tv.push_back('{1'b1, 2'd1, 12'hF14, 32'h0,         32'h0,         1'b1});
      tv.push_back('{1'b1, 2'd2, 12'hC80, 32'h0,         32'h0,         1'b0});
      tv.push_back('{1'b1, 2'd2, 12'hF14, 32'h0,         HART_ID,       1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h301, 32'hFFFF_FFFF, 32'h4000_0100, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h301, 32'h0,         32'h4000_0100, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h305, 32'h0000_0107, MTVEC_RST,     1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h305, 32'h0,         32'h0000_0104, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h341, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h341, 32'h0,         32'hFFFF_FFFC, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h300, 32'h0,         32'h0000_1888, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h304, 32'h0,         32'h0000_0800, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h344, 32'hFFFF_FFFF, 32'h0,         1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h344, 32'h0,         32'h0,         1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h342, 32'h1234_5678, 32'h0,         1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h342, 32'h0,         32'h1234_5678, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h343, 32'hCAFE_BABE, 32'h0,         1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h343, 32'h0,         32'hCAFE_BABE, 1'b0});
      tv.push_back('{1'b1, 2'd1, 12'h300, 32'h0000_0008, 32'h0000_1888, 1'b0});
      tv.push_back('{1'b0, 2'd0, 12'h300, 32'h0,         32'h0000_1808, 1'b0});

      // Reset: two edges, observe reset state during and after.
      @(negedge clk);
      tick();
      rd("rst_mstatus_during", 12'h300, 32'h0000_1800);
      chk("rst_redirect", {31'b0, redirect}, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      tick();
      rst = 0;
      rd("rst_mcycle0", 12'hB00, 32'h0);
      tick();
      rd("rst_mcycle1", 12'hB00, 32'h1);
      tick();

      for (int i = 0; i < tv.size(); i++) begin
         csr(tv[i].we, tv[i].op, tv[i].addr, tv[i].src);
         #1;
         chk($sformatf("vec%0d_dout", i), csr_dout, tv[i].dout);
         chk($sformatf("vec%0d_ill", i), {31'b0, illegal_csr}, {31'b0, tv[i].ill});
         tick();
      end

      // Trap entry with mtvec=0x104, MIE=1.
      trap_valid = 1; trap_pc = 32'h0000_0042; trap_cause = 32'h2; trap_val = 32'h55;
      #1;
      chk("trap_no_early_redirect", {31'b0, redirect}, 32'h0);
      tick();
      chk("trap_redirect", {31'b0, redirect}, 32'h1);
      chk("trap_redirect_pc", redirect_pc, 32'h0000_0104);
      rd("trap_mepc", 12'h341, 32'h0000_0040);
      tick();
      chk("trap_redirect_one_cycle", {31'b0, redirect}, 32'h0);
      rd("trap_mstatus", 12'h300, 32'h0000_1880);
      tick();
      rd("trap_mcause", 12'h342, 32'h2);
      tick();
      rd("trap_mtval", 12'h343, 32'h55);
      mret = 1;
      tick();
      chk("mret_redirect", {31'b0, redirect}, 32'h1);
      chk("mret_redirect_pc", redirect_pc, 32'h0000_0040);
      rd("mret_mstatus", 12'h300, 32'h0000_1888);
      tick();

      // Trap, mret and CSR write in the same cycle: only the trap acts.
      trap_valid = 1; trap_pc = 32'h0000_0080; trap_cause = 32'h8000_000B;
      mret = 1;
      csr(1'b1, 2'b01, 12'h340, 32'h1);
      #1;
      chk("simul_dout", csr_dout, 32'h00A5_00FF);
      tick();
      chk("simul_redirect", {31'b0, redirect}, 32'h1);
      chk("simul_redirect_pc", redirect_pc, 32'h0000_0104);
      rd("simul_mscratch", 12'h340, 32'h00A5_00FF);
      tick();
      chk("simul_single_pulse", {31'b0, redirect}, 32'h0);
      rd("simul_mstatus", 12'h300, 32'h0000_1880);
      rd("simul_mcause", 12'h342, 32'h8000_000B);
      mret = 1;
      tick();
      chk("simul_mret_pc", redirect_pc, 32'h0000_0080);
      tick();

      // External interrupt through the synchroniser, then masked via RC.
      ext_irq = 1;
      #1;
      chk("irq_before", {31'b0, irq_req}, 32'h0);
      tick();
      chk("irq_after_1", {31'b0, irq_req}, 32'h0);
      tick();
      chk("irq_after_2", {31'b0, irq_req}, 32'h1);
      rd("irq_mip", 12'h344, 32'h0000_0800);
      csr(1'b1, 2'b11, 12'h300, 32'h8);
      #1;
      chk("irq_rc_dout", csr_dout, 32'h0000_1888);
      tick();
      chk("irq_masked", {31'b0, irq_req}, 32'h0);
      ext_irq = 0;

      // Illegal write to read-only counter alias; counter keeps running.
      csr(1'b1, 2'b01, 12'hC00, 32'h5);
      #1;
      chk("ill_cycle_flag", {31'b0, illegal_csr}, 32'h1);
      chk("ill_cycle_dout", csr_dout, 32'h0);
      tick();
      rd("cnt_running", 12'hB00, ncyc);
      tick();
      rd("cnt_running2", 12'hB00, ncyc);
      rd("cnt_high0", 12'hB80, 32'h0);

      // Low-half write and carry into the high half.
      csr(1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF);
      tick();
      rd("cnt_written", 12'hB00, 32'hFFFF_FFFF);
      tick();
      rd("cnt_carry_hi", 12'hB80, 32'h1);
      tick();
      rd("cnt_lo_after", 12'hB00, 32'h1);
      tick();
      rd("cnt_alias_hi", 12'hC80, 32'h1);
      csr(1'b1, 2'b01, 12'hB80, 32'h0);
      tick();
      rd("cnt_hi_written", 12'hB80, 32'h0);

      // Reset beats a simultaneous trap and write, cancelling the redirect.
      rst = 1;
      trap_valid = 1; trap_pc = 32'h0000_0300;
      csr(1'b1, 2'b01, 12'h340, 32'h9);
      tick();
      rst = 0;
      chk("rstwin_redirect", {31'b0, redirect}, 32'h0);
      rd("rstwin_mscratch", 12'h340, 32'h0);
      rd("rstwin_mtvec", 12'h305, MTVEC_RST);
      rd("rstwin_mepc", 12'h341, 32'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
